// File: rtl/rv_timer_mc_pkg.sv
// rv_timer_mc_pkg: shared definitions for the multi-hart, multi-comparator machine timer.
// Holds the register map offsets, the per-channel and per-hart configuration structs and
// their reset values.
package rv_timer_mc_pkg;

  // Global and per-hart register map (byte addresses)
  localparam int unsigned CTRL         = 32'h000;
  localparam int unsigned HART_BASE    = 32'h100;
  localparam int unsigned HART_STRIDE  = 32'h100;
  localparam int unsigned CFG_OFS      = 32'h00;
  localparam int unsigned MTIME_LO_OFS = 32'h04;
  localparam int unsigned MTIME_HI_OFS = 32'h08;

  // Per-channel register map, relative to the hart base
  localparam int unsigned CH_BASE      = 32'h20;
  localparam int unsigned CH_STRIDE    = 32'h20;
  localparam int unsigned CMP_LO_OFS   = 32'h00;
  localparam int unsigned CMP_HI_OFS   = 32'h04;
  localparam int unsigned PERIOD_OFS   = 32'h08;
  localparam int unsigned CHCTRL_OFS   = 32'h0C;
  localparam int unsigned STATE_OFS    = 32'h10;
  localparam int unsigned TEST_OFS     = 32'h14;

  typedef struct packed {
    logic [63:0] cmp;
    logic [31:0] period;
    logic        enable;
    logic        periodic;
  } chan_cfg_t;

  typedef struct packed {
    logic [11:0] prescale;
    logic [7:0]  step;
  } hart_cfg_t;

  localparam chan_cfg_t CHAN_CFG_RST = '{cmp: '1, period: '0, enable: 1'b0, periodic: 1'b0};
  localparam hart_cfg_t HART_CFG_RST = '{prescale: '0, step: 8'd1};

  // CFG register image: prescale[11:0], step[23:16]
  function automatic logic [31:0] hart_cfg_word(hart_cfg_t c);
    return {8'd0, c.step, 4'd0, c.prescale};
  endfunction

endpackage

// File: rtl/rv_timer_mc_chan.sv
// rv_timer_mc_chan: one compare channel. Holds compare, period and control registers plus the
// sticky STATE bit, performs the 64-bit unsigned hit test and the periodic compare reload.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   mtime_i           owning hart's mtime
//   wdata_i           bus write data
//   *_we_i            decoded, error-free write strobes for this channel's registers
//   cfg_o             current register contents (for read-back)
//   state_o           STATE bit
//   intr_o            registered STATE & intr_enable
module rv_timer_mc_chan
  import rv_timer_mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] mtime_i,
  input  logic [31:0] wdata_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic        period_we_i,
  input  logic        chctrl_we_i,
  input  logic        state_we_i,
  input  logic        test_we_i,
  output chan_cfg_t   cfg_o,
  output logic        state_o,
  output logic        intr_o
);

  chan_cfg_t cfg_q, cfg_d;
  logic      state_q, state_d, intr_q;
  logic      hit, cmp_we, reload;

  assign hit    = (mtime_i >= cfg_q.cmp);
  assign cmp_we = cmp_lo_we_i | cmp_hi_we_i;
  // Reload only on a hit-driven 0->1 edge; a software compare write in the same cycle wins.
  assign reload = hit & ~state_q & ~cmp_we & cfg_q.periodic & (cfg_q.period != '0);

  always_comb begin
    cfg_d = cfg_q;
    if (cmp_lo_we_i) begin
      cfg_d.cmp[31:0] = wdata_i;
    end else if (cmp_hi_we_i) begin
      cfg_d.cmp[63:32] = wdata_i;
    end else if (reload) begin
      cfg_d.cmp = cfg_q.cmp + {32'd0, cfg_q.period};
    end
    if (period_we_i) begin
      cfg_d.period = wdata_i;
    end
    if (chctrl_we_i) begin
      cfg_d.enable   = wdata_i[0];
      cfg_d.periodic = wdata_i[1];
    end

    // Compare write clears, then set (hit/TEST) beats W1C.
    state_d = state_q;
    if (cmp_we) begin
      state_d = 1'b0;
    end else if (hit || test_we_i) begin
      state_d = 1'b1;
    end else if (state_we_i && wdata_i[0]) begin
      state_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_q   <= CHAN_CFG_RST;
      state_q <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      intr_q  <= state_q & cfg_q.enable;
    end
  end

  assign cfg_o   = cfg_q;
  assign state_o = state_q;
  assign intr_o  = intr_q;

endmodule

// File: rtl/rv_timer_mc.sv
// rv_timer_mc: multi-hart RISC-V machine timer. Each hart has a 12-bit prescaler, an 8-bit
// step and a 64-bit mtime; each hart owns N_TIMERS compare channels (rv_timer_mc_chan).
// Optional build macro RV_TIMER_MC_MTIME_SNAPSHOT_EN: a MTIME_LO read latches mtime[63:32]
// into a per-hart shadow that MTIME_HI reads return, giving tear-free LO-then-HI reads.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   reg_we/reg_re   register write/read strobes
//   reg_addr        byte address
//   reg_wdata       write data, reg_be byte enables (partial writes are errors)
//   reg_rdata       combinational read data, 0 when not reading
//   reg_error       combinational access error (unmapped address or partial write)
//   intr_o          bit h*N_TIMERS+t = hart h, channel t
module rv_timer_mc
  import rv_timer_mc_pkg::*;
#(
  parameter int unsigned N_HARTS  = 2,
  parameter int unsigned N_TIMERS = 2,
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         reg_we,
  input  logic                         reg_re,
  input  logic [AW-1:0]                reg_addr,
  input  logic [DW-1:0]                reg_wdata,
  input  logic [DW/8-1:0]              reg_be,
  output logic [DW-1:0]                reg_rdata,
  output logic                         reg_error,
  output logic [N_HARTS*N_TIMERS-1:0]  intr_o
);

  localparam int unsigned NCH = N_HARTS * N_TIMERS;

  logic                ctrl_sel;
  logic [N_HARTS-1:0]  cfg_sel, lo_sel, hi_sel;
  logic [NCH-1:0]      cmplo_sel, cmphi_sel, period_sel, chctrl_sel, state_sel, test_sel;
  logic                mapped, wr_en, rd_en;

  logic [N_HARTS-1:0]  ctrl_q;
  logic [63:0]         mtime [N_HARTS];
  logic [31:0]         mtime_hi_rd [N_HARTS];
  hart_cfg_t           hart_cfg [N_HARTS];
  chan_cfg_t           chan_cfg [NCH];
  logic [NCH-1:0]      chan_state;

  // Address decode: exact word matches only, so unaligned addresses fall out as unmapped.
  always_comb begin
    int unsigned a, hb, cb;
    a  = 32'(reg_addr);
    hb = 0;
    cb = 0;
    cfg_sel    = '0;
    lo_sel     = '0;
    hi_sel     = '0;
    cmplo_sel  = '0;
    cmphi_sel  = '0;
    period_sel = '0;
    chctrl_sel = '0;
    state_sel  = '0;
    test_sel   = '0;
    ctrl_sel   = (a == CTRL);
    for (int unsigned h = 0; h < N_HARTS; h++) begin
      hb = HART_BASE + h * HART_STRIDE;
      cfg_sel[h] = (a == hb + CFG_OFS);
      lo_sel[h]  = (a == hb + MTIME_LO_OFS);
      hi_sel[h]  = (a == hb + MTIME_HI_OFS);
      for (int unsigned t = 0; t < N_TIMERS; t++) begin
        cb = hb + CH_BASE + t * CH_STRIDE;
        cmplo_sel[h*N_TIMERS+t]  = (a == cb + CMP_LO_OFS);
        cmphi_sel[h*N_TIMERS+t]  = (a == cb + CMP_HI_OFS);
        period_sel[h*N_TIMERS+t] = (a == cb + PERIOD_OFS);
        chctrl_sel[h*N_TIMERS+t] = (a == cb + CHCTRL_OFS);
        state_sel[h*N_TIMERS+t]  = (a == cb + STATE_OFS);
        test_sel[h*N_TIMERS+t]   = (a == cb + TEST_OFS);
      end
    end
  end

  assign mapped = ctrl_sel | (|cfg_sel) | (|lo_sel) | (|hi_sel) | (|cmplo_sel) | (|cmphi_sel) |
                  (|period_sel) | (|chctrl_sel) | (|state_sel) | (|test_sel);
  assign reg_error = (reg_re | reg_we) & (~mapped | (reg_we & (reg_be != '1)));
  assign wr_en = reg_we & ~reg_error;
  assign rd_en = reg_re & ~reg_error;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
    end else if (wr_en && ctrl_sel) begin
      ctrl_q <= reg_wdata[N_HARTS-1:0];
    end
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    hart_cfg_t   cfg_q, cfg_d;
    logic [11:0] pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    assign tick = ctrl_q[h] && (pcnt_q == cfg_q.prescale);

    always_comb begin
      cfg_d = cfg_q;
      if (wr_en && cfg_sel[h]) begin
        cfg_d.prescale = reg_wdata[11:0];
        cfg_d.step     = reg_wdata[23:16];
      end
      pcnt_d = (!ctrl_q[h] || tick) ? 12'd0 : pcnt_q + 12'd1;
      // Software writes to either half take the cycle; no increment alongside.
      mtime_d = mtime_q;
      if (wr_en && lo_sel[h]) begin
        mtime_d[31:0] = reg_wdata;
      end else if (wr_en && hi_sel[h]) begin
        mtime_d[63:32] = reg_wdata;
      end else if (tick) begin
        mtime_d = mtime_q + 64'(cfg_q.step);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cfg_q   <= HART_CFG_RST;
        pcnt_q  <= '0;
        mtime_q <= '0;
      end else begin
        cfg_q   <= cfg_d;
        pcnt_q  <= pcnt_d;
        mtime_q <= mtime_d;
      end
    end

    assign mtime[h]    = mtime_q;
    assign hart_cfg[h] = cfg_q;

`ifdef RV_TIMER_MC_MTIME_SNAPSHOT_EN
    logic [31:0] shadow_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        shadow_q <= '0;
      end else if (rd_en && lo_sel[h]) begin
        shadow_q <= mtime_q[63:32];
      end
    end
    assign mtime_hi_rd[h] = shadow_q;
`else
    assign mtime_hi_rd[h] = mtime_q[63:32];
`endif

    for (genvar t = 0; t < N_TIMERS; t++) begin : g_chan
      localparam int unsigned I = h * N_TIMERS + t;
      rv_timer_mc_chan u_chan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mtime_i     (mtime_q),
        .wdata_i     (reg_wdata),
        .cmp_lo_we_i (wr_en & cmplo_sel[I]),
        .cmp_hi_we_i (wr_en & cmphi_sel[I]),
        .period_we_i (wr_en & period_sel[I]),
        .chctrl_we_i (wr_en & chctrl_sel[I]),
        .state_we_i  (wr_en & state_sel[I]),
        .test_we_i   (wr_en & test_sel[I]),
        .cfg_o       (chan_cfg[I]),
        .state_o     (chan_state[I]),
        .intr_o      (intr_o[I])
      );
    end
  end

  // Read mux; TEST and unmapped/erroring accesses read as zero.
  always_comb begin
    reg_rdata = '0;
    if (rd_en) begin
      if (ctrl_sel) reg_rdata = 32'(ctrl_q);
      for (int unsigned h = 0; h < N_HARTS; h++) begin
        if (cfg_sel[h]) reg_rdata = hart_cfg_word(hart_cfg[h]);
        if (lo_sel[h])  reg_rdata = mtime[h][31:0];
        if (hi_sel[h])  reg_rdata = mtime_hi_rd[h];
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cmplo_sel[i])  reg_rdata = chan_cfg[i].cmp[31:0];
        if (cmphi_sel[i])  reg_rdata = chan_cfg[i].cmp[63:32];
        if (period_sel[i]) reg_rdata = chan_cfg[i].period;
        if (chctrl_sel[i]) reg_rdata = {30'd0, chan_cfg[i].periodic, chan_cfg[i].enable};
        if (state_sel[i])  reg_rdata = {31'd0, chan_state[i]};
      end
    end
  end

endmodule
